inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised IF→ID decoupling queue that replaces the single-entry fetch/decode latch with its one-word skid memory. Buffers up to DEPTH fetched instructions, each with its PC and fetch exception code, under a valid/ready handshake on both sides. Converts cancelled fetch responses into marked NOPs with masked exceptions. Empties in one cycle on writeback exception/ertn flush.

## Interface

Parameters:

- DEPTH, 4: number of entries; power of two, ≥2.
- PC_W, 32: PC width.
- INST_W, 32: instruction width.
- EXC_W, 2: fetch exception code width (TLB refill/invalid etc.).
- NOP_INST, 32'h02800000: instruction substituted for cancelled/empty slots.
- RESET_PC, 32'h1bfffffc: out_pc value while empty.

Ports:

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  writeback exception or ertn; discards all contents.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_pc  in  PC_W  fetch PC.
- in_inst  in  INST_W  fetched instruction.
- in_exc  in  EXC_W  fetch exception code.
- in_discard  in  1  response belongs to a cancelled fetch.
- out_valid  out  1  head entry present.
- out_ready  in  1  ID accepts head.
- out_pc  out  PC_W  head PC.
- out_inst  out  INST_W  head instruction.
- out_exc  out  EXC_W  head exception code.
- out_cancelled  out  1  head was a discarded response.
- count  out  $clog2(DEPTH+1)  occupancy.

## Operation

- Storage: DEPTH-entry register array, {pc, inst, exc, cancelled}; write and read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter tracked separately so full and empty are unambiguous.
- Push: in_valid && in_ready.
  - Stores pc = in_pc.
  - If in_discard=0: stores inst = in_inst, exc = in_exc, cancelled = 0.
  - If in_discard=1: stores inst = NOP_INST, exc = 0, cancelled = 1.
- Pop: out_valid && out_ready; advances the read pointer.
- in_ready = (count != DEPTH). No combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- When empty: out_pc = RESET_PC, out_inst = NOP_INST, out_exc = 0, out_cancelled = 0.
- When not empty: outputs show the entry at the read pointer (combinational read of registered storage).
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. This is legal at any non-full, non-empty occupancy, and at empty only the push takes effect.
- flush: count, write pointer and read pointer set to 0 on the next edge. A same-cycle push or pop is ignored, so the entry is lost and not stored.
- rst: same effect as flush. Storage contents need not be cleared.
- in_valid of X/Z is not treated as valid. Benches drive known values.

## Timing

- Reset values (cycle after rst):
  - out_valid = 0, in_ready = 1, count = 0.
  - out_pc = RESET_PC, out_inst = NOP_INST, out_exc = 0, out_cancelled = 0.
- Latency: an entry pushed at edge N is visible as out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- Full: in_ready drops in the cycle after the DEPTH-th push. It rises the cycle after a pop from full.
- Flush has priority over rst-free push/pop. In the cycle after flush: out_valid = 0, in_ready = 1, count = 0.
- Pointer wrap: after index DEPTH−1 the next write/read index is 0, with no bubble.

## Test plan

- Reset then idle:
  - Stimulus: rst high 2 cycles, then hold out_ready=0, in_valid=0.
  - Required: out_valid=0, out_pc=32'h1bfffffc, out_inst=32'h02800000, count=0, in_ready=1.
- Fill and drain (DEPTH=4):
  - Stimulus: push PCs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c with out_ready=0.
  - Required: in_ready=0 and count=4 after the 4th push. Then with out_ready=1, outputs drain in order, one per cycle, and count returns to 0.
- Discard conversion:
  - Stimulus: push pc=0x1c000010, inst=0x00100c41, exc=2'b01, in_discard=1.
  - Required: head shows pc=0x1c000010, inst=0x02800000, exc=0, cancelled=1.
- Simultaneous push/pop with wrap:
  - Stimulus: stream 10 instructions with in_valid and out_ready both held high.
  - Required: count stays 1 after the first cycle, outputs arrive in order across pointer wrap, and nothing is dropped or duplicated.
- Flush mid-stream:
  - Stimulus: with count=3, assert flush together with a push (pc=0x1c000020) and a pop.
  - Required: next cycle count=0 and out_valid=0. A subsequent push of 0x1c000024 appears as the head after one cycle.
- Full boundary pop+push:
  - Stimulus: with count=4, assert out_ready=1 and in_valid=1.
  - Required: the pop occurs, the push is refused (in_ready=0), and count=3. The next cycle in_ready=1 and the push is accepted.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// IF->ID decoupling queue: DEPTH-entry FIFO of {pc, inst, exc, cancelled} with
// valid/ready on both sides, discard-to-NOP conversion and single-cycle flush.
module inst_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter int                EXC_W    = 2,
  parameter logic [INST_W-1:0] NOP_INST = 32'h02800000,
  parameter logic [PC_W-1:0]   RESET_PC = 32'h1bfffffc
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PC_W-1:0]              in_pc,
  input  logic [INST_W-1:0]            in_inst,
  input  logic [EXC_W-1:0]             in_exc,
  input  logic                         in_discard,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [INST_W-1:0]            out_inst,
  output logic [EXC_W-1:0]             out_exc,
  output logic                         out_cancelled,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [EXC_W-1:0]  exc_mem  [DEPTH];
  logic              canc_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             pop;

  // Handshake flags depend only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  // Pointers and occupancy; flush and reset both discard everything, including same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A cancelled fetch keeps its PC but becomes a marked NOP with no exception.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr] <= in_pc;
      if (in_discard) begin
        inst_mem[wr_ptr] <= NOP_INST;
        exc_mem[wr_ptr]  <= '0;
        canc_mem[wr_ptr] <= 1'b1;
      end else begin
        inst_mem[wr_ptr] <= in_inst;
        exc_mem[wr_ptr]  <= in_exc;
        canc_mem[wr_ptr] <= 1'b0;
      end
    end
  end

  always_comb begin
    out_pc        = RESET_PC;
    out_inst      = NOP_INST;
    out_exc       = '0;
    out_cancelled = 1'b0;
    if (out_valid) begin
      out_pc        = pc_mem[rd_ptr];
      out_inst      = inst_mem[rd_ptr];
      out_exc       = exc_mem[rd_ptr];
      out_cancelled = canc_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue model of the expected contents
// is updated on every modelled push/pop/flush and compared against the head.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h02800000;
  localparam logic [31:0] RPC = 32'h1bfffffc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  exc;
    logic        canc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic [1:0]  in_exc = '0;
  logic        in_discard = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  out_exc;
  logic        out_cancelled;
  logic [2:0]  count;

  entry_t sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  bit     checks_on = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_exc(in_exc), .in_discard(in_discard),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_exc(out_exc), .out_cancelled(out_cancelled),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs depend only on registered state, so they are stable once inputs settle at negedge.
  task automatic checkOutput();
    entry_t head;
    chk("count", 64'(count), 64'(sb.size()));
    chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) head = sb[0];
    else head = '{pc: RPC, inst: NOP, exc: 2'b00, canc: 1'b0};
    chk("out_pc", 64'(out_pc), 64'(head.pc));
    chk("out_inst", 64'(out_inst), 64'(head.inst));
    chk("out_exc", 64'(out_exc), 64'(head.exc));
    chk("out_cancelled", 64'(out_cancelled), 64'(head.canc));
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [1:0] exc, input logic disc, input logic rdy,
                               input logic fl, input logic rs);
    bit do_push, do_pop;
    entry_t e;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_inst = inst; in_exc = exc; in_discard = disc;
    out_ready = rdy; flush = fl; rst = rs;
    #1;
    if (checks_on) checkOutput();
    do_push = v && (sb.size() != DEPTH);
    do_pop  = rdy && (sb.size() != 0);
    e.pc   = pc;
    e.inst = disc ? NOP : inst;
    e.exc  = disc ? 2'b00 : exc;
    e.canc = disc;
    @(posedge clk);
    if (rs || fl) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] exc,
                       input logic disc, input logic rdy);
    applyStimulus(1'b1, pc, inst, exc, disc, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then idle
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    checks_on = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // Fill to full with out_ready low, then drain in order
    for (int i = 0; i < 4; i++)
      push1(32'h1c000000 + 32'(i * 4), 32'h00100000 + 32'(i), 2'(i), 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Discarded response becomes a marked NOP
    push1(32'h1c000010, 32'h00100c41, 2'b01, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    push1(32'h1c000014, 32'h00100c42, 2'b10, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Streaming push+pop across pointer wrap
    for (int i = 0; i < 10; i++)
      push1(32'h1c000100 + 32'(i * 4), 32'h00200000 + 32'(i), 2'(i), 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // Flush with concurrent push and pop at count 3
    for (int i = 0; i < 3; i++)
      push1(32'h1c000200 + 32'(i * 4), 32'h00300000 + 32'(i), 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1c000020, 32'h00300020, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    push1(32'h1c000024, 32'h00300024, 2'b10, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Full boundary: pop accepted, push refused, then retried
    for (int i = 0; i < 4; i++)
      push1(32'h1c000300 + 32'(i * 4), 32'h00400000 + 32'(i), 2'b00, 1'b0, 1'b0);
    push1(32'h1c000310, 32'h00400010, 2'b01, 1'b0, 1'b1);
    push1(32'h1c000310, 32'h00400010, 2'b01, 1'b0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Random mix of traffic with occasional flushes
    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom_range(0, 1)), 32'h1c001000 + 32'(i * 4), $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
